invader_march_ctrl: RTL and testbench
=====================================

Name: invader_march_ctrl

Overview:
- Frame-tick-driven sequencer for the 50-entry invader sprite table.
- On every enabled march tick it scans all entries to find the alive count, the formation's horizontal extent and the lowest row. It then decides one move: left, right, or step-down-and-reverse. Finally it read-modify-writes every alive entry.
- Shares the table port with the renderer through a req/gnt handshake; the renderer always has priority.

Parameters:
- N, 50: number of table entries, addresses 0..N-1.
- STEP, 3: horizontal pixels per move.
- SPR_W, 32: sprite width in pixels.
- SCREEN_W, 640: visible width in pixels.
- ROW_LIMIT, 14: highest legal row index; the formation must not go below it.

Ports:
- clk25M, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: game in play state; when 0, ticks are ignored.
- frame_tick, in, 1: single-cycle pulse, once per frame.
- move_div, in, 4: move once every move_div+1 enabled ticks.
- restart, in, 1: pulse; clears game_over and dir, and resets the divider.
- tbl_req, out, 1: table port requested.
- tbl_gnt, in, 1: table port granted this cycle.
- tbl_addr, out, 6: entry address.
- tbl_re, out, 1: read strobe.
- tbl_rdata, in, 40: read data, valid exactly 1 cycle after a cycle with tbl_re&tbl_gnt.
- tbl_we, out, 1: write strobe.
- tbl_wdata, out, 40: write data.
- busy, out, 1: march in progress.
- dir, out, 1: 0 = moving right, 1 = moving left.
- alive_cnt, out, 6: alive count from the last scan.
- step_done, out, 1: 1-cycle pulse when a march completes.
- cleared, out, 1: 1-cycle pulse when a scan finds no alive entries.
- game_over, out, 1: sticky flag.
- missed_tick, out, 1: 1-cycle pulse when frame_tick arrives while busy.

Behaviour:
- Entry format:
  - [39] exist
  - [38:36] id
  - [35:24] row
  - [23:12] hpos (unsigned, pixels)
  - [11:0] color
- Reset (async, active-low): state IDLE, divider 0; all outputs 0.
- Tick handling:
  - A tick counts only when enable=1, game_over=0 and state=IDLE.
  - When the divider equals move_div, the block enters SCAN and the divider clears; otherwise the divider increments.
  - A tick while busy (any state other than IDLE) pulses missed_tick and is dropped; the divider does not change.
- Table strobes:
  - tbl_req=1 in every state except IDLE and DECIDE.
  - tbl_re and tbl_we may assert only together with tbl_req.
  - An access is performed only in a cycle with tbl_gnt=1; otherwise address and strobes hold until the grant.
- SCAN:
  - Issue reads for addresses 0..N-1 in order, one per granted cycle.
  - For each returned entry with exist=1, accumulate: alive count, min hpos, max hpos, max row.
  - After the data for address N-1 returns, go to DECIDE.
- DECIDE (1 cycle):
  - alive=0: pulse cleared, go to IDLE with no writes; alive_cnt=0.
  - dir=0 and maxh+STEP+SPR_W > SCREEN_W: down-move.
  - dir=1 and minh < STEP: down-move.
  - Otherwise: horizontal move, +STEP (dir=0) or -STEP (dir=1).
  - Down-move with maxrow+1 > ROW_LIMIT: set game_over, go to IDLE, no writes.
  - Down-move otherwise: row+1, hpos unchanged, toggle dir at the end of the UPDATE pass.
  - alive_cnt updates in this cycle.
- UPDATE:
  - For i=0..N-1: UREAD issues the read for i; UWRITE receives the data.
  - exist=0: skip the write.
  - exist=1: write the entry with only row or hpos modified. Arithmetic is 12-bit; the edge checks guarantee no wrap.
  - After entry N-1, pulse step_done, apply the dir toggle if pending, go to IDLE.
- restart:
  - Takes effect in IDLE only; in any other state it is ignored.
  - game_over=0, dir=0, divider=0.
  - If restart and a tick occur in the same IDLE cycle, restart wins and the tick is dropped.
- Reset mid-operation: immediately return to IDLE; writes already performed are not undone.
- Minimum march duration with constant gnt: SCAN N+1 cycles, DECIDE 1 cycle, UPDATE 2N cycles.

Test Plan:
- Entries 0..14 alive at hpos 0/320 alternating, row = index, dir=0, move_div=0, gnt=1, one tick:
  - all alive hpos +3 (0->3, 320->323).
  - step_done pulses after 152 cycles; alive_cnt=15.
- Single alive entry at hpos 606, dir=0, tick:
  - 606+3+32=641>640 -> row+1, hpos 606 kept, dir=1.
  - next tick: hpos 603.
- Entry at hpos 2, dir=1, row 14 (=ROW_LIMIT), tick:
  - game_over=1, no tbl_we pulses.
  - subsequent ticks ignored until restart, which clears game_over and dir.
- All exist=0, tick: cleared pulses after the scan; zero writes; alive_cnt=0.
- gnt toggling 1,0,1,0 during the march: final table identical to the constant-gnt run; no access occurs in a gnt=0 cycle.
- move_div=2, ticks every 10 cycles: marches start on ticks 3, 6, 9.
  - a tick arriving mid-march pulses missed_tick.
  - asserting reset mid-UPDATE returns to IDLE with busy=0 at once.

Source files
------------

// File: rtl/invader_march_ctrl.sv
// Invader formation march sequencer.
// Each enabled march tick scans the sprite table for the alive count, the
// horizontal extent and the lowest row, decides one move (left, right or
// step-down-and-reverse), then read-modify-writes every alive entry. The
// table port is shared with the renderer through tbl_req/tbl_gnt.
// Ports:
//   clk25M, reset (async, active-low)
//   enable, frame_tick, move_div, restart     : game control inputs
//   tbl_req/tbl_gnt/tbl_addr/tbl_re/tbl_rdata : table read port
//   tbl_we/tbl_wdata                          : table write port (combinational,
//                                               driven in the cycle the read data returns)
//   busy, dir, alive_cnt, step_done, cleared, game_over, missed_tick : status
module invader_march_ctrl #(
    parameter int unsigned N         = 50,
    parameter int unsigned STEP      = 3,
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned ROW_LIMIT = 14
) (
    input  logic        clk25M,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [3:0]  move_div,
    input  logic        restart,
    output logic        tbl_req,
    input  logic        tbl_gnt,
    output logic [5:0]  tbl_addr,
    output logic        tbl_re,
    input  logic [39:0] tbl_rdata,
    output logic        tbl_we,
    output logic [39:0] tbl_wdata,
    output logic        busy,
    output logic        dir,
    output logic [5:0]  alive_cnt,
    output logic        step_done,
    output logic        cleared,
    output logic        game_over,
    output logic        missed_tick
);

    localparam int unsigned AW = 6;
    localparam int unsigned CW = 12;
    localparam int unsigned XW = CW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_UREAD  = 3'd3;
    localparam logic [2:0] S_UWRITE = 3'd4;

    typedef struct packed {
        logic          exist;
        logic [2:0]    id;
        logic [CW-1:0] row;
        logic [CW-1:0] hpos;
        logic [CW-1:0] color;
    } entry_t;

    logic [2:0]    state,     state_nx;
    logic [3:0]    div_q,     div_nx;
    logic [AW-1:0] addr_nx;
    logic          req_nx,    re_nx;
    logic          rd_valid,  rd_valid_nx;
    logic          rd_last,   rd_last_nx;
    logic [AW-1:0] cnt,       cnt_nx;
    logic [CW-1:0] minh,      minh_nx;
    logic [CW-1:0] maxh,      maxh_nx;
    logic [CW-1:0] maxrow,    maxrow_nx;
    logic          mode_down, mode_down_nx;
    logic          tog_pend,  tog_pend_nx;
    entry_t        held,      held_nx;
    logic          busy_nx,   dir_nx,  step_done_nx, cleared_nx;
    logic          game_over_nx, missed_tick_nx;
    logic [AW-1:0] alive_cnt_nx;

    entry_t        rd_e, cur_e, wr_e;
    logic          last_addr, edge_hit, row_over;

    // State and registered outputs
    always_ff @(posedge clk25M or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            div_q       <= '0;
            tbl_addr    <= '0;
            tbl_req     <= 1'b0;
            tbl_re      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            cnt         <= '0;
            minh        <= '0;
            maxh        <= '0;
            maxrow      <= '0;
            mode_down   <= 1'b0;
            tog_pend    <= 1'b0;
            held        <= '0;
            busy        <= 1'b0;
            dir         <= 1'b0;
            alive_cnt   <= '0;
            step_done   <= 1'b0;
            cleared     <= 1'b0;
            game_over   <= 1'b0;
            missed_tick <= 1'b0;
        end else begin
            state       <= state_nx;
            div_q       <= div_nx;
            tbl_addr    <= addr_nx;
            tbl_req     <= req_nx;
            tbl_re      <= re_nx;
            rd_valid    <= rd_valid_nx;
            rd_last     <= rd_last_nx;
            cnt         <= cnt_nx;
            minh        <= minh_nx;
            maxh        <= maxh_nx;
            maxrow      <= maxrow_nx;
            mode_down   <= mode_down_nx;
            tog_pend    <= tog_pend_nx;
            held        <= held_nx;
            busy        <= busy_nx;
            dir         <= dir_nx;
            alive_cnt   <= alive_cnt_nx;
            step_done   <= step_done_nx;
            cleared     <= cleared_nx;
            game_over   <= game_over_nx;
            missed_tick <= missed_tick_nx;
        end
    end

    // Next-state, datapath and write-port logic
    always_comb begin
        state_nx       = state;
        div_nx         = div_q;
        addr_nx        = tbl_addr;
        req_nx         = tbl_req;
        re_nx          = tbl_re;
        rd_valid_nx    = tbl_re & tbl_gnt;
        rd_last_nx     = tbl_re & tbl_gnt & (tbl_addr == AW'(N - 1));
        cnt_nx         = cnt;
        minh_nx        = minh;
        maxh_nx        = maxh;
        maxrow_nx      = maxrow;
        mode_down_nx   = mode_down;
        tog_pend_nx    = tog_pend;
        held_nx        = held;
        dir_nx         = dir;
        alive_cnt_nx   = alive_cnt;
        step_done_nx   = 1'b0;
        cleared_nx     = 1'b0;
        game_over_nx   = game_over;
        missed_tick_nx = frame_tick & (state != S_IDLE);
        tbl_we         = 1'b0;
        tbl_wdata      = '0;

        last_addr = (tbl_addr == AW'(N - 1));
        rd_e      = entry_t'(tbl_rdata);
        // Read data is valid for one cycle only; a stalled write replays the held copy.
        cur_e     = rd_valid ? rd_e : held;
        wr_e      = cur_e;
        if (mode_down)
            wr_e.row = CW'(cur_e.row + CW'(1));
        else if (dir)
            wr_e.hpos = CW'(cur_e.hpos - CW'(STEP));
        else
            wr_e.hpos = CW'(cur_e.hpos + CW'(STEP));

        edge_hit = dir ? (minh < CW'(STEP))
                       : ((XW'(maxh) + XW'(STEP + SPR_W)) > XW'(SCREEN_W));
        row_over = (XW'(maxrow) + XW'(1)) > XW'(ROW_LIMIT);

        case (state)
            S_IDLE: begin
                if (restart) begin
                    game_over_nx = 1'b0;
                    dir_nx       = 1'b0;
                    div_nx       = '0;
                end else if (frame_tick && enable && !game_over) begin
                    if (div_q == move_div) begin
                        div_nx    = '0;
                        state_nx  = S_SCAN;
                        req_nx    = 1'b1;
                        re_nx     = 1'b1;
                        addr_nx   = '0;
                        cnt_nx    = '0;
                        minh_nx   = '1;
                        maxh_nx   = '0;
                        maxrow_nx = '0;
                    end else begin
                        div_nx = 4'(div_q + 4'd1);
                    end
                end
            end
            S_SCAN: begin
                if (tbl_re && tbl_gnt) begin
                    if (last_addr) re_nx = 1'b0;
                    else           addr_nx = AW'(tbl_addr + AW'(1));
                end
                if (rd_valid && rd_e.exist) begin
                    cnt_nx = AW'(cnt + AW'(1));
                    if (rd_e.hpos < minh)  minh_nx   = rd_e.hpos;
                    if (rd_e.hpos > maxh)  maxh_nx   = rd_e.hpos;
                    if (rd_e.row > maxrow) maxrow_nx = rd_e.row;
                end
                if (rd_last) begin
                    state_nx = S_DECIDE;
                    req_nx   = 1'b0;
                end
            end
            S_DECIDE: begin
                alive_cnt_nx = cnt;
                if (cnt == '0) begin
                    cleared_nx = 1'b1;
                    state_nx   = S_IDLE;
                end else if (edge_hit && row_over) begin
                    game_over_nx = 1'b1;
                    state_nx     = S_IDLE;
                end else begin
                    mode_down_nx = edge_hit;
                    tog_pend_nx  = edge_hit;
                    state_nx     = S_UREAD;
                    req_nx       = 1'b1;
                    re_nx        = 1'b1;
                    addr_nx      = '0;
                end
            end
            S_UREAD: begin
                if (tbl_gnt) begin
                    state_nx = S_UWRITE;
                    re_nx    = 1'b0;
                end
            end
            S_UWRITE: begin
                held_nx   = cur_e;
                tbl_we    = cur_e.exist;
                tbl_wdata = cur_e.exist ? wr_e : '0;
                // Dead entries skip the write and need no grant.
                if (!cur_e.exist || tbl_gnt) begin
                    if (last_addr) begin
                        state_nx     = S_IDLE;
                        req_nx       = 1'b0;
                        step_done_nx = 1'b1;
                        if (tog_pend) dir_nx = ~dir;
                    end else begin
                        state_nx = S_UREAD;
                        re_nx    = 1'b1;
                        addr_nx  = AW'(tbl_addr + AW'(1));
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                req_nx   = 1'b0;
                re_nx    = 1'b0;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_invader_march_ctrl.sv
module tb_invader_march_ctrl;

    logic        clk25M = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_tick;
    logic [3:0]  move_div;
    logic        restart;
    logic        tbl_req;
    logic        tbl_gnt = 1'b1;
    logic [5:0]  tbl_addr;
    logic        tbl_re;
    logic [39:0] tbl_rdata = '0;
    logic        tbl_we;
    logic [39:0] tbl_wdata;
    logic        busy, dir, step_done, cleared, game_over, missed_tick;
    logic [5:0]  alive_cnt;

    logic [39:0] mem      [0:49];
    logic [39:0] init_tbl [0:49];
    logic [39:0] exp_tbl  [0:49];
    logic        load_req = 1'b0;
    logic        gnt_toggle = 1'b0;
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    logic        prev_hold = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic        prev_re = 1'b0;
    logic        prev_we = 1'b0;

    invader_march_ctrl dut (
        .clk25M      (clk25M),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .move_div    (move_div),
        .restart     (restart),
        .tbl_req     (tbl_req),
        .tbl_gnt     (tbl_gnt),
        .tbl_addr    (tbl_addr),
        .tbl_re      (tbl_re),
        .tbl_rdata   (tbl_rdata),
        .tbl_we      (tbl_we),
        .tbl_wdata   (tbl_wdata),
        .busy        (busy),
        .dir         (dir),
        .alive_cnt   (alive_cnt),
        .step_done   (step_done),
        .cleared     (cleared),
        .game_over   (game_over),
        .missed_tick (missed_tick)
    );

    always #20 clk25M = ~clk25M;

    // Grant: constant or alternating 1,0,1,0
    always @(negedge clk25M) begin
        if (gnt_toggle) tbl_gnt = ~tbl_gnt;
        else            tbl_gnt = 1'b1;
    end

    // Sprite table model: read data one cycle after a granted read
    always @(posedge clk25M) begin
        if (load_req) begin
            for (int i = 0; i < 50; i++) mem[i] <= init_tbl[i];
            wr_count <= 0;
        end else begin
            if (tbl_gnt && tbl_re) tbl_rdata <= mem[tbl_addr];
            if (tbl_gnt && tbl_we) begin
                mem[tbl_addr] <= tbl_wdata;
                wr_count      <= wr_count + 1;
            end
        end
    end

    // Port protocol monitor: strobes only with req, and stalled accesses hold
    always @(posedge clk25M) begin
        if (reset) begin
            if (tbl_re || tbl_we) begin
                checks++;
                assert (tbl_req === 1'b1) else begin
                    errors++;
                    $error("FAIL strobe_without_req: req=%0b re=%0b we=%0b expected req=1", tbl_req, tbl_re, tbl_we);
                end
            end
            if (prev_hold) begin
                checks++;
                assert ({tbl_addr, tbl_re, tbl_we} === {prev_addr, prev_re, prev_we}) else begin
                    errors++;
                    $error("FAIL stall_hold: addr/re/we=%0d/%0b/%0b expected %0d/%0b/%0b",
                           tbl_addr, tbl_re, tbl_we, prev_addr, prev_re, prev_we);
                end
            end
        end
        prev_hold <= reset && (tbl_re || tbl_we) && !tbl_gnt;
        prev_addr <= tbl_addr;
        prev_re   <= tbl_re;
        prev_we   <= tbl_we;
    end

    function automatic logic [39:0] mk(input logic ex, input int id, input int row,
                                       input int hpos, input int color);
        return {ex, 3'(id), 12'(row), 12'(hpos), 12'(color)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_table;
        @(negedge clk25M);
        load_req = 1'b1;
        @(negedge clk25M);
        load_req = 1'b0;
    endtask

    task automatic do_tick;
        @(negedge clk25M);
        frame_tick = 1'b1;
        @(posedge clk25M);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_restart;
        @(negedge clk25M);
        restart = 1'b1;
        @(posedge clk25M);
        #1;
        restart = 1'b0;
    endtask

    // which: 0 = step_done, 1 = cleared, 2 = busy low. Bounded by budget cycles.
    task automatic wait_event(input string tag, input int which, input int budget, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(posedge clk25M);
            #1;
            cyc++;
            if (which == 0)      seen = step_done;
            else if (which == 1) seen = cleared;
            else                 seen = !busy;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 50; i++) check(tag, 64'(mem[i]), 64'(exp_tbl[i]));
    endtask

    initial begin
        int cyc;
        int wr0;
        reset      = 1'b0;
        enable     = 1'b1;
        frame_tick = 1'b0;
        move_div   = 4'd0;
        restart    = 1'b0;
        repeat (3) @(posedge clk25M);
        @(negedge clk25M);
        reset = 1'b1;
        #1;

        // Reset state
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_dir",       64'(dir),       64'd0);
        check("rst_alive",     64'(alive_cnt), 64'd0);
        check("rst_game_over", 64'(game_over), 64'd0);
        check("rst_req",       64'(tbl_req),   64'd0);
        check("rst_we",        64'(tbl_we),    64'd0);

        // Right move: entries 0..14 alive, hpos 0/320 alternating
        for (int i = 0; i < 50; i++) begin
            if (i < 15) begin
                init_tbl[i] = mk(1'b1, i % 8, i, (i % 2 == 1) ? 320 : 0, i);
                exp_tbl[i]  = mk(1'b1, i % 8, i, (i % 2 == 1) ? 323 : 3, i);
            end else begin
                init_tbl[i] = mk(1'b0, i % 8, 0, 55, i);
                exp_tbl[i]  = init_tbl[i];
            end
        end
        load_table();
        do_tick();
        check("t1_busy", 64'(busy), 64'd1);
        wait_event("t1_step_done", 0, 400, cyc);
        check("t1_latency", 64'(cyc), 64'd152);
        check("t1_alive",   64'(alive_cnt), 64'd15);
        check("t1_dir",     64'(dir), 64'd0);
        check("t1_writes",  64'(wr_count), 64'd15);
        check_table("t1_entry");

        // Same march with alternating grant must give the same table
        load_table();
        gnt_toggle = 1'b1;
        do_tick();
        wait_event("gnt_step_done", 0, 1000, cyc);
        gnt_toggle = 1'b0;
        check("gnt_writes", 64'(wr_count), 64'd15);
        check_table("gnt_entry");

        // Right edge: 606+3+32 > 640 -> step down, reverse
        for (int i = 0; i < 50; i++) init_tbl[i] = mk(1'b0, 0, 0, 0, 0);
        init_tbl[5] = mk(1'b1, 2, 3, 606, 'h0AB);
        load_table();
        do_tick();
        wait_event("t2_step_done", 0, 400, cyc);
        check("t2_down_entry", 64'(mem[5]), 64'(mk(1'b1, 2, 4, 606, 'h0AB)));
        check("t2_dir",        64'(dir), 64'd1);
        check("t2_alive",      64'(alive_cnt), 64'd1);
        do_tick();
        wait_event("t2b_step_done", 0, 400, cyc);
        check("t2_left_entry", 64'(mem[5]), 64'(mk(1'b1, 2, 4, 603, 'h0AB)));
        check("t2b_dir",       64'(dir), 64'd1);

        // Left edge at row limit -> game over, no writes
        for (int i = 0; i < 50; i++) init_tbl[i] = mk(1'b0, 0, 0, 0, 0);
        init_tbl[7] = mk(1'b1, 1, 14, 2, 'h123);
        load_table();
        do_tick();
        wait_event("t3_idle", 2, 200, cyc);
        check("t3_latency",  64'(cyc), 64'd52);
        check("t3_game_over", 64'(game_over), 64'd1);
        check("t3_writes",   64'(wr_count), 64'd0);
        check("t3_entry",    64'(mem[7]), 64'(mk(1'b1, 1, 14, 2, 'h123)));
        check("t3_dir",      64'(dir), 64'd1);
        do_tick();
        check("t3_tick_ignored", 64'(busy), 64'd0);
        check("t3_no_missed",    64'(missed_tick), 64'd0);
        do_restart();
        check("t3_restart_go",  64'(game_over), 64'd0);
        check("t3_restart_dir", 64'(dir), 64'd0);

        // Empty table -> cleared, no writes
        for (int i = 0; i < 50; i++) init_tbl[i] = mk(1'b0, i % 8, i % 15, 7 * i, i);
        load_table();
        do_tick();
        wait_event("t4_cleared", 1, 200, cyc);
        check("t4_latency", 64'(cyc), 64'd52);
        check("t4_alive",   64'(alive_cnt), 64'd0);
        check("t4_writes",  64'(wr_count), 64'd0);
        check("t4_busy",    64'(busy), 64'd0);

        // Divider: marches on ticks 3, 6, 9; missed tick; reset mid-UPDATE
        for (int i = 0; i < 50; i++) init_tbl[i] = mk(1'b0, 0, 0, 0, 0);
        init_tbl[0] = mk(1'b1, 0, 0, 100, 0);
        load_table();
        move_div = 4'd2;
        for (int t = 1; t <= 9; t++) begin
            repeat (10) @(posedge clk25M);
            do_tick();
            check($sformatf("t5_start_tick%0d", t), 64'(busy), (t % 3 == 0) ? 64'd1 : 64'd0);
            if (t == 3 || t == 6) begin
                repeat (9) @(posedge clk25M);
                do_tick();
                check("t5_missed", 64'(missed_tick), 64'd1);
                check("t5_missed_busy", 64'(busy), 64'd1);
                wait_event("t5_step_done", 0, 400, cyc);
            end
        end
        wr0 = wr_count;
        check("t5_writes_before", 64'(wr0), 64'd2);
        repeat (78) @(posedge clk25M);
        check("t5_mid_update_busy", 64'(busy), 64'd1);
        @(negedge clk25M);
        reset = 1'b0;
        #1;
        check("t5_reset_busy", 64'(busy), 64'd0);
        check("t5_reset_req",  64'(tbl_req), 64'd0);
        check("t5_reset_re",   64'(tbl_re), 64'd0);
        check("t5_kept_write", 64'(mem[0]), 64'(mk(1'b1, 0, 0, 109, 0)));
        @(negedge clk25M);
        reset = 1'b1;
        repeat (3) @(posedge clk25M);
        #1;
        check("t5_after_busy",  64'(busy), 64'd0);
        check("t5_after_entry", 64'(mem[0]), 64'(mk(1'b1, 0, 0, 109, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
